// File: rtl/key_debounce.sv
// key_debounce
//   Conditions an active-low mechanical push-button. The raw pin is passed
//   through a two-flop synchroniser, then a four-state FSM accepts a level
//   change only after STABLE_CYCLES+1 consecutive agreeing samples. While the
//   key is held, a saturating 32-bit counter measures the press. That count
//   drives a one-shot long-press strobe and the captured press length.
//
// Ports
//   clk        : system clock (40 MHz board clock)
//   rst        : synchronous active-high reset
//   key_in     : raw asynchronous button pin, 0 = pressed
//   key_level  : debounced level, 0 = pressed
//   key_fall   : one-cycle strobe on accepted press
//   key_rise   : one-cycle strobe on accepted release
//   long_press : one-cycle strobe when the hold count reaches LONG_CYCLES
//   press_len  : length of the last completed press in clk cycles
module key_debounce #(
   parameter int unsigned STABLE_CYCLES = 400000,
   parameter int unsigned CNT_W         = 20,
   parameter logic [31:0] LONG_CYCLES   = 32'd40000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        key_in,
   output logic        key_level,
   output logic        key_fall,
   output logic        key_rise,
   output logic        long_press,
   output logic [31:0] press_len
);

   typedef enum logic [1:0] {
      RELEASED,
      FALL_CHK,
      PRESSED,
      RISE_CHK
   } state_t;

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(STABLE_CYCLES - 1);
   // hold_cnt value one edge before it reaches LONG_CYCLES.
   localparam logic [31:0]      LONG_PRE = LONG_CYCLES - 32'd1;

   state_t           state;
   logic             sync_1, sync_2;
   logic [CNT_W-1:0] deb_cnt;
   logic [31:0]      hold_cnt;
   logic [31:0]      hold_next;
   logic             long_hit;

   // The counter sticks at all-ones. LONG_PRE can never be all-ones, so the
   // long-press match happens at most once per press.
   assign hold_next = (hold_cnt == 32'hFFFF_FFFF) ? hold_cnt : hold_cnt + 32'd1;
   assign long_hit  = (hold_cnt == LONG_PRE);

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_1     <= 1'b1;
         sync_2     <= 1'b1;
         state      <= RELEASED;
         deb_cnt    <= '0;
         hold_cnt   <= '0;
         key_level  <= 1'b1;
         key_fall   <= 1'b0;
         key_rise   <= 1'b0;
         long_press <= 1'b0;
         press_len  <= '0;
      end else begin
         sync_1     <= key_in;
         sync_2     <= sync_1;
         key_fall   <= 1'b0;
         key_rise   <= 1'b0;
         long_press <= 1'b0;

         case (state)
            RELEASED: begin
               key_level <= 1'b1;
               if (!sync_2) begin
                  state   <= FALL_CHK;
                  deb_cnt <= '0;
               end
            end

            FALL_CHK: begin
               if (sync_2) begin
                  state <= RELEASED;      // glitch: outputs untouched
               end else if (deb_cnt == DEB_LAST) begin
                  state     <= PRESSED;
                  key_level <= 1'b0;
                  key_fall  <= 1'b1;
                  hold_cnt  <= 32'd1;
               end else begin
                  deb_cnt <= deb_cnt + 1'b1;
               end
            end

            PRESSED: begin
               hold_cnt   <= hold_next;
               long_press <= long_hit;
               if (sync_2) begin
                  state   <= RISE_CHK;
                  deb_cnt <= '0;
               end
            end

            RISE_CHK: begin
               if (!sync_2) begin
                  // Release bounce: the press carries on, so the count keeps going.
                  state      <= PRESSED;
                  hold_cnt   <= hold_next;
                  long_press <= long_hit;
               end else if (deb_cnt == DEB_LAST) begin
                  // Release accepted. The count stops here, so no long
                  // press can fire on this edge.
                  state     <= RELEASED;
                  key_level <= 1'b1;
                  key_rise  <= 1'b1;
                  press_len <= hold_cnt;
                  hold_cnt  <= '0;
               end else begin
                  deb_cnt    <= deb_cnt + 1'b1;
                  hold_cnt   <= hold_next;
                  long_press <= long_hit;
               end
            end

            default: state <= RELEASED;
         endcase
      end
   end

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce
//   Drives directed and random key patterns into key_debounce. A reference
//   model works on the synchronised sample stream, which is the pin delayed
//   by two edges and forced high for two edges after reset. A level change
//   is accepted once STABLE+1 consecutive samples disagree with the current
//   level. Press length is the gap between the fall edge and the rise edge.
//   A long press is due LONG-1 edges after the fall edge while the key is
//   still down. Expected strobe events are queued. A monitor on the falling
//   clock edge pops and compares them as the DUT raises strobes. It also
//   checks the level and the press length every cycle.
module tb_key_debounce;

   localparam int ST = 4;
   localparam int LG = 10;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        key_in = 1'b1;
   logic        key_level, key_fall, key_rise, long_press;
   logic [31:0] press_len;

   always #5 clk = ~clk;

   key_debounce #(
      .STABLE_CYCLES(ST),
      .CNT_W        (3),
      .LONG_CYCLES  (32'(LG))
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .key_in    (key_in),
      .key_level (key_level),
      .key_fall  (key_fall),
      .key_rise  (key_rise),
      .long_press(long_press),
      .press_len (press_len)
   );

   typedef struct {
      int          cyc;
      bit          fall;
      bit          rise;
      bit          lp;
      bit          level;
      logic [31:0] plen;
   } ev_t;

   ev_t sb[$];
   int  checks = 0;
   int  errors = 0;

   // Reference model state.
   int          cyc = 0;
   bit          m_level = 1'b1;
   logic [31:0] m_plen = '0;
   int          run = 0;
   int          fall_t = 0;
   int          since_rst = 0;
   bit          k1 = 1'b1, k2 = 1'b1;

   always @(posedge clk) begin : model
      ev_t e;
      bit  s;
      cyc++;
      if (rst) begin
         m_level   = 1'b1;
         m_plen    = '0;
         run       = 0;
         since_rst = 0;
      end else begin
         since_rst++;
         s = (since_rst <= 2) ? 1'b1 : k2;
         e.cyc = cyc; e.fall = 0; e.rise = 0; e.lp = 0; e.level = 0; e.plen = '0;
         if (s != m_level) run++;
         else run = 0;
         if (run == ST + 1) begin
            run     = 0;
            m_level = ~m_level;
            if (!m_level) begin
               fall_t = cyc;
               e.fall = 1'b1;
            end else begin
               m_plen = 32'(cyc - fall_t);
               e.rise = 1'b1;
            end
         end
         if (!m_level && cyc == fall_t + LG - 1) e.lp = 1'b1;
         if (e.fall || e.rise || e.lp) begin
            e.level = m_level;
            e.plen  = m_plen;
            sb.push_back(e);
         end
      end
      k2 = k1;
      k1 = key_in;
   end

   always @(negedge clk) begin : monitor
      ev_t e;
      checks++;
      if (key_level !== m_level || press_len !== m_plen) begin
         errors++;
         $display("FAIL level_len cyc=%0d got level=%b len=%0d want level=%b len=%0d",
                  cyc, key_level, press_len, m_level, m_plen);
      end
      // Expected events whose cycle has passed without a DUT strobe.
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
         e = sb.pop_front();
         checks++; errors++;
         $display("FAIL missed_strobe want cyc=%0d fall=%b rise=%b lp=%b now cyc=%0d",
                  e.cyc, e.fall, e.rise, e.lp, cyc);
      end
      if (key_fall === 1'b1 || key_rise === 1'b1 || long_press === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_strobe cyc=%0d got fall=%b rise=%b lp=%b want none",
                     cyc, key_fall, key_rise, long_press);
         end else begin
            e = sb.pop_front();
            if (e.cyc != cyc || e.fall !== key_fall || e.rise !== key_rise ||
                e.lp !== long_press || e.level !== key_level || e.plen !== press_len) begin
               errors++;
               $display("FAIL strobe cyc=%0d got f=%b r=%b lp=%b lvl=%b len=%0d want cyc=%0d f=%b r=%b lp=%b lvl=%b len=%0d",
                        cyc, key_fall, key_rise, long_press, key_level, press_len,
                        e.cyc, e.fall, e.rise, e.lp, e.level, e.plen);
            end
         end
      end
   end

   task automatic drive(input bit v, input int n);
      key_in = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask

   initial begin
      rst = 1'b1;
      key_in = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Idle after reset.
      drive(1'b1, 20);
      chk("idle_level", 32'(key_level), 32'd1);
      chk("idle_len", press_len, 32'd0);

      // Clean 30-cycle press with a long press.
      drive(1'b0, 30);
      drive(1'b1, 12);
      chk("len30", press_len, 32'd30);

      // Short glitches must stay invisible.
      repeat (5) begin
         drive(1'b0, 3);
         drive(1'b1, 3);
      end
      drive(1'b1, 10);
      chk("glitch_level", 32'(key_level), 32'd1);
      chk("glitch_len", press_len, 32'd30);

      // Release bounce inside a press. The bounce is counted in the length.
      drive(1'b0, 8);
      drive(1'b1, 2);
      drive(1'b0, 10);
      drive(1'b1, 12);
      chk("len_bounce", press_len, 32'd20);

      // Press shorter than the long-press threshold.
      drive(1'b0, 7);
      drive(1'b1, 12);
      chk("len7", press_len, 32'd7);

      // Reset while pressed, key still held. The press must be debounced again.
      drive(1'b0, 12);
      rst = 1'b1;
      drive(1'b0, 1);
      rst = 1'b0;
      chk("rst_level", 32'(key_level), 32'd1);
      chk("rst_len", press_len, 32'd0);
      drive(1'b0, 14);
      drive(1'b1, 12);

      // Random segments with occasional reset pulses.
      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 14) == 0) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end
         drive(1'($urandom_range(0, 1)), int'($urandom_range(1, 14)));
      end

      drive(1'b1, 20);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL leftover_events got=%0d want=0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
